// File: rtl/histogram_pkg.sv
// Shared constants, state encoding and index helper for the histogram readout.
// Build option: HISTOGRAM_CLEAR_ON_READ_EN adds the CLEAR state (clear-on-read).
package histogram_pkg;

    localparam int BIN_W   = 32;
    localparam int WORD_W  = 128;
    localparam int LANES   = 4;
    localparam int LANE_W  = 2;
    localparam int INDEX_W = 8;
    localparam int ADDR_W  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_WAIT = 3'd2,
        EMIT    = 3'd3,
`ifdef HISTOGRAM_CLEAR_ON_READ_EN
        CLEAR   = 3'd4,
`endif
        FIN     = 3'd5
    } state_t;

    // Bin number of a lane within a scratch word: word*LANES + lane.
    function automatic logic [INDEX_W-1:0] bin_index(input logic [INDEX_W-1:0] word,
                                                      input logic [LANE_W-1:0]  lane);
        return INDEX_W'(word << LANE_W) | INDEX_W'(lane);
    endfunction

endpackage

// File: rtl/histogram_lane_mux.sv
// Selects one 32-bit bin count out of a 128-bit scratch word.
// Lane 0 is the most significant slice, lane 3 the least significant.
module histogram_lane_mux
    import histogram_pkg::*;
(
    input  logic [WORD_W-1:0] hold,
    input  logic [LANE_W-1:0] lane,
    output logic [BIN_W-1:0]  count
);

    // Fixed MSB-first lane order.
    always_comb begin
        count = '0;
        case (lane)
            2'd0:    count = hold[WORD_W-1          -: BIN_W];
            2'd1:    count = hold[WORD_W-1-BIN_W    -: BIN_W];
            2'd2:    count = hold[WORD_W-1-2*BIN_W  -: BIN_W];
            default: count = hold[WORD_W-1-3*BIN_W  -: BIN_W];
        endcase
    end

endmodule

// File: rtl/histogram_readout.sv
// Histogram readout: walks NUM_WORDS scratch words, streams 4 bins per word
// over a valid/ready port and, when built with HISTOGRAM_CLEAR_ON_READ_EN,
// zeroes each word after its last bin has been accepted.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start
// RD_ADDR | scratch address = ADDR_BASE + word, read issued
// RD_WAIT | read data arrives, captured into the holding register
// EMIT    | present bin (word, lane) until accepted; 4 transfers per word
// CLEAR   | single write of 0 to the same word (clear-on-read build only)
// FIN     | one-cycle done pulse, then back to IDLE
module histogram_readout #(
    parameter int NUM_WORDS = 64,
    parameter int ADDR_BASE = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [15:0]  scratch_memory_address_pointer,
    input  logic [127:0] scratch_memory_rdata,
    output logic         scratch_memory_write_enable,
    output logic [127:0] scratch_memory_wdata,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_bin_index,
    output logic [31:0]  out_bin_count,
    output logic         out_last
);
    import histogram_pkg::*;

    localparam int WORD_CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(NUM_WORDS - 1);
    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);

    state_t                  state_q, state_d;
    logic [WORD_CNT_W-1:0]   word_q,  word_d;
    logic [LANE_W-1:0]       lane_q,  lane_d;
    logic [WORD_W-1:0]       hold_q,  hold_d;

    logic                    emit;
    logic                    xfer;
    logic                    last_lane;
    logic                    last_word;
    logic                    advance;
    logic [ADDR_W-1:0]       word_addr;
    logic [BIN_W-1:0]        lane_count;

    assign emit      = (state_q == EMIT);
    assign xfer      = emit && out_ready;
    assign last_lane = (lane_q == LAST_LANE);
    assign last_word = (word_q == LAST_WORD);
    assign word_addr = ADDR_W'(ADDR_BASE) + ADDR_W'(word_q);

    histogram_lane_mux u_lane_mux (
        .hold  (hold_q),
        .lane  (lane_q),
        .count (lane_count)
    );

    // State, counters and holding register; synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            lane_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic; the next-word decision is shared by EMIT (no clear)
    // and CLEAR (clear-on-read) through the advance strobe.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        lane_d  = lane_q;
        hold_d  = hold_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_ADDR;
                    word_d  = '0;
                end
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: begin
                hold_d  = scratch_memory_rdata;
                lane_d  = '0;
                state_d = EMIT;
            end
            EMIT: begin
                if (xfer) begin
                    lane_d = lane_q + LANE_W'(1);
                    if (last_lane) begin
`ifdef HISTOGRAM_CLEAR_ON_READ_EN
                        state_d = CLEAR;
`else
                        advance = 1'b1;
`endif
                    end
                end
            end
`ifdef HISTOGRAM_CLEAR_ON_READ_EN
            CLEAR: advance = 1'b1;
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (last_word) begin
                state_d = FIN;
            end else begin
                word_d  = word_q + WORD_CNT_W'(1);
                state_d = RD_ADDR;
            end
        end
    end

    // Outputs decoded from the registered state; idle values are all zero.
    always_comb begin
        busy                           = (state_q != IDLE);
        done                           = (state_q == FIN);
        out_valid                      = emit;
        out_bin_index                  = '0;
        out_bin_count                  = '0;
        out_last                       = 1'b0;
        scratch_memory_address_pointer = '0;
        scratch_memory_write_enable    = 1'b0;
        scratch_memory_wdata           = '0;

        if (emit) begin
            out_bin_index = bin_index(INDEX_W'(word_q), lane_q);
            out_bin_count = lane_count;
            out_last      = last_word && last_lane;
        end

        if (state_q == RD_ADDR) begin
            scratch_memory_address_pointer = word_addr;
        end

`ifdef HISTOGRAM_CLEAR_ON_READ_EN
        // A reset landing on the CLEAR cycle must not let the write through.
        if (state_q == CLEAR) begin
            scratch_memory_address_pointer = word_addr;
            scratch_memory_write_enable    = !reset;
        end
`endif
    end

endmodule

// File: tb/tb_histogram_readout.sv
// Self-checking bench for histogram_readout: a 2-word and a 64-word instance
// share clock/reset, each backed by a small scratch memory; expected bins are
// derived from a word-level model of memory contents.
module tb_histogram_readout;

`ifdef HISTOGRAM_CLEAR_ON_READ_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic         start_drv = 1'b0;
    logic         ready_drv = 1'b1;
    logic         sel_big   = 1'b0;

    logic         start_s, busy_s, done_s, we_s, valid_s, last_s;
    logic [15:0]  addr_s;
    logic [127:0] rdata_s = '0, wdata_s;
    logic [7:0]   idx_s;
    logic [31:0]  cnt_s;

    logic         start_b, busy_b, done_b, we_b, valid_b, last_b;
    logic [15:0]  addr_b;
    logic [127:0] rdata_b = '0, wdata_b;
    logic [7:0]   idx_b;
    logic [31:0]  cnt_b;

    assign start_s = start_drv && !sel_big;
    assign start_b = start_drv && sel_big;

    histogram_readout #(.NUM_WORDS(2), .ADDR_BASE(0)) dut_small (
        .clock                          (clock),
        .reset                          (reset),
        .start                          (start_s),
        .busy                           (busy_s),
        .done                           (done_s),
        .scratch_memory_address_pointer (addr_s),
        .scratch_memory_rdata           (rdata_s),
        .scratch_memory_write_enable    (we_s),
        .scratch_memory_wdata           (wdata_s),
        .out_valid                      (valid_s),
        .out_ready                      (ready_drv),
        .out_bin_index                  (idx_s),
        .out_bin_count                  (cnt_s),
        .out_last                       (last_s)
    );

    histogram_readout #(.NUM_WORDS(64), .ADDR_BASE(0)) dut_big (
        .clock                          (clock),
        .reset                          (reset),
        .start                          (start_b),
        .busy                           (busy_b),
        .done                           (done_b),
        .scratch_memory_address_pointer (addr_b),
        .scratch_memory_rdata           (rdata_b),
        .scratch_memory_write_enable    (we_b),
        .scratch_memory_wdata           (wdata_b),
        .out_valid                      (valid_b),
        .out_ready                      (ready_drv),
        .out_bin_index                  (idx_b),
        .out_bin_count                  (cnt_b),
        .out_last                       (last_b)
    );

    // Views of whichever instance is under test.
    logic         m_busy, m_done, m_we, m_valid, m_last;
    logic [15:0]  m_addr;
    logic [127:0] m_wdata;
    logic [7:0]   m_idx;
    logic [31:0]  m_cnt;
    assign m_busy  = sel_big ? busy_b  : busy_s;
    assign m_done  = sel_big ? done_b  : done_s;
    assign m_we    = sel_big ? we_b    : we_s;
    assign m_valid = sel_big ? valid_b : valid_s;
    assign m_last  = sel_big ? last_b  : last_s;
    assign m_addr  = sel_big ? addr_b  : addr_s;
    assign m_wdata = sel_big ? wdata_b : wdata_s;
    assign m_idx   = sel_big ? idx_b   : idx_s;
    assign m_cnt   = sel_big ? cnt_b   : cnt_s;

    // Scratch memories: registered read, write port from DUT or bench fill.
    logic [127:0] mem_s [2];
    logic [127:0] mem_b [64];
    logic         fill_we  = 1'b0;
    logic         fill_big = 1'b0;
    logic [5:0]   fill_a   = '0;
    logic [127:0] fill_d   = '0;

    always @(posedge clock) begin
        rdata_s <= mem_s[addr_s[0]];
        rdata_b <= mem_b[addr_b[5:0]];
        if (fill_we && !fill_big)  mem_s[fill_a[0]] <= fill_d;
        else if (we_s)             mem_s[addr_s[0]] <= wdata_s;
        if (fill_we && fill_big)   mem_b[fill_a]    <= fill_d;
        else if (we_b)             mem_b[addr_b[5:0]] <= wdata_b;
    end

    // Reference model of scratch contents, maintained from the bench's view.
    logic [127:0] mdl_s [2];
    logic [127:0] mdl_b [64];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill(input bit big, input int w, input logic [127:0] d);
        fill_big = big;
        fill_a   = 6'(w);
        fill_d   = d;
        fill_we  = 1'b1;
        if (big) mdl_b[w] = d; else mdl_s[w] = d;
        @(negedge clock);
        fill_we  = 1'b0;
    endtask

    // Run one drain and check every bin, write and done pulse against the model.
    task automatic drain(input bit big, input int stall_idx, input int stall_len,
                         input bit rnd, input bit poke);
        int           nw;
        int           q_idx[$];
        logic [31:0]  q_cnt[$];
        int           wq[$];
        logic [127:0] word;
        int           cyc, busy_cyc, done_n, last_xfer, stall_n;
        bit           seen, rdy, stall_hold, all_ready;

        nw = big ? 64 : 2;
        sel_big = big;
        for (int w = 0; w < nw; w++) begin
            word = big ? mdl_b[w] : mdl_s[w];
            for (int l = 0; l < 4; l++) begin
                q_idx.push_back(w * 4 + l);
                q_cnt.push_back(32'(word >> (96 - 32 * l)));
            end
            if (CLR == 1) wq.push_back(w);
        end

        all_ready = !rnd && (stall_len == 0);
        cyc = 0; busy_cyc = 0; done_n = 0; last_xfer = -100; stall_n = 0;
        seen = 0; stall_hold = 0;

        @(negedge clock);
        start_drv = 1'b1;
        ready_drv = 1'b1;
        while (cyc < 3000) begin
            @(negedge clock);
            cyc++;
            start_drv = poke && (cyc == 3);
            if (m_busy) begin
                busy_cyc++;
                seen = 1;
            end else if (seen) begin
                break;
            end

            if (m_done) begin
                done_n++;
                chk("done_gap", 64'(cyc - last_xfer), 64'(1 + CLR));
            end

            if (m_we) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", m_we, 0);
                end else begin
                    chk("wr_addr", m_addr, 64'(wq[0]));
                    chk("wr_data", 64'(m_wdata[127:64] | m_wdata[63:0]), 0);
                    void'(wq.pop_front());
                end
            end

            if (stall_hold) chk("stall_valid", m_valid, 1);
            stall_hold = 0;

            rdy = 1'b1;
            if (rnd) rdy = ($urandom_range(0, 3) != 0);
            if (m_valid && (int'(m_idx) == stall_idx) && (stall_n < stall_len)) begin
                rdy = 1'b0;
                stall_n++;
                stall_hold = 1;
            end
            ready_drv = rdy;

            if (m_valid) begin
                if (q_idx.size() == 0) begin
                    chk("extra_bin", m_valid, 0);
                end else begin
                    chk("bin_index", m_idx, 64'(q_idx[0]));
                    chk("bin_count", m_cnt, 64'(q_cnt[0]));
                    chk("bin_last", m_last, 64'(q_idx[0] == 4 * nw - 1));
                    chk("emit_bus_idle", 64'(m_addr) | 64'(m_we), 0);
                    if (rdy) begin
                        void'(q_idx.pop_front());
                        void'(q_cnt.pop_front());
                        last_xfer = cyc;
                    end
                end
            end
        end
        ready_drv = 1'b1;
        start_drv = 1'b0;

        chk("drain_in_budget", 64'(cyc < 3000), 1);
        chk("bins_left", 64'(q_idx.size()), 0);
        chk("writes_left", 64'(wq.size()), 0);
        chk("done_pulses", 64'(done_n), 1);
        chk("stall_cycles", 64'(stall_n), 64'(stall_len));
        if (all_ready) chk("drain_cycles", 64'(busy_cyc), 64'(nw * (6 + CLR) + 1));

        if (CLR == 1) begin
            for (int w = 0; w < nw; w++) begin
                if (big) mdl_b[w] = '0; else mdl_s[w] = '0;
            end
        end

        repeat (4) begin
            @(negedge clock);
            chk("idle_after_drain", 64'(m_busy) | 64'(m_done) | 64'(m_valid), 0);
        end
    endtask

    // Reset mid-drain on the big instance around word 5 and check it goes quiet.
    task automatic reset_mid();
        bit found;
        int cyc;
        sel_big = 1'b1;
        found = 0;
        cyc = 0;
        @(negedge clock);
        start_drv = 1'b1;
        ready_drv = 1'b1;
        while (cyc < 1000 && !found) begin
            @(negedge clock);
            cyc++;
            start_drv = 1'b0;
            if (CLR == 1) found = m_we && (m_addr == 16'd5);
            else          found = m_valid && (m_idx == 8'd22);
        end
        chk("reset_trigger_seen", 64'(found), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_we", m_we, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_valid", m_valid, 0);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clock);
            chk("post_rst_quiet", 64'(m_we) | 64'(m_busy), 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_small_flags", {busy_s, done_s, we_s, valid_s, last_s}, 0);
        chk("rst_small_addr", addr_s, 0);
        chk("rst_small_wdata", 64'(wdata_s[127:64] | wdata_s[63:0]), 0);
        chk("rst_small_bin", {idx_s, cnt_s}, 0);
        chk("rst_big_flags", {busy_b, done_b, we_b, valid_b, last_b}, 0);
        chk("rst_big_addr", addr_b, 0);
        chk("rst_big_bin", {idx_b, cnt_b}, 0);

        // Known pattern in word 0, ready always high.
        fill(0, 0, {32'h1, 32'h2, 32'h3, 32'h4});
        fill(0, 1, rnd128());
        drain(0, -1, 0, 0, 0);

        // Stall 5 cycles on bin 2.
        fill(0, 0, rnd128());
        fill(0, 1, rnd128());
        drain(0, 2, 5, 0, 0);

        // start pulsed while busy must be ignored.
        fill(0, 0, rnd128());
        fill(0, 1, rnd128());
        drain(0, -1, 0, 0, 1);

        // Full 64-word drain, all-ones final bin.
        for (int w = 0; w < 64; w++) begin
            fill(1, w, (w == 63) ? {rnd128() >> 32, 32'hFFFF_FFFF} : rnd128());
        end
        drain(1, -1, 0, 0, 0);

        // Second drain with random backpressure (all zero after clear-on-read).
        drain(1, -1, 0, 1, 0);

        // Reset mid-drain, then refill and confirm a clean drain afterwards.
        for (int w = 0; w < 64; w++) fill(1, w, rnd128());
        reset_mid();
        for (int w = 0; w < 64; w++) fill(1, w, rnd128());
        drain(1, 37, 3, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
